// File: rtl/sram_port_arbiter_if.sv
// One SRAM-like request/response port: req/addr_ok address phase, data_ok/rdata response.
// master drives the request fields, slave drives the handshakes and read data.
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between inst (M0) and data (M1); routes in-order responses by a tag FIFO.
// Latency 0 (combinational); a refused address phase keeps its grant, new grants stall while OUTST are pending.
module sram_port_arbiter #(
  parameter int OUTST      = 2,
  parameter int MAX_STREAK = 4
) (
  input logic                 clk,
  input logic                 reset,
  sram_port_arbiter_if.slave  inst,
  sram_port_arbiter_if.slave  data,
  sram_port_arbiter_if.master sram
);
  localparam int PW = $clog2(OUTST);
  localparam int CW = $clog2(OUTST + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [OUTST-1:0] tag_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             lock_vld;
  logic             lock_src;
  logic [SW-1:0]    streak;

  logic fifo_full;
  logic grant_src;
  logic grant_req;
  logic accept;
  logic pop;
  logic head;

  // A held (locked) request outranks everything; a saturated streak lets M0 jump ahead of M1.
  always_comb begin
    grant_src = 1'b0;
    if (lock_vld)
      grant_src = lock_src;
    else if (streak == SW'(MAX_STREAK) && inst.req)
      grant_src = 1'b0;
    else if (data.req)
      grant_src = 1'b1;
  end

  assign fifo_full = (count == CW'(OUTST));
  assign grant_req = !fifo_full && (grant_src ? data.req : inst.req);
  assign accept    = grant_req && sram.addr_ok;
  assign pop       = sram.data_ok && (count != '0);
  assign head      = tag_q[rd_ptr];

  assign sram.req   = grant_req;
  assign sram.wr    = grant_req && (grant_src ? data.wr : inst.wr);
  assign sram.size  = {2{grant_req}}  & (grant_src ? data.size  : inst.size);
  assign sram.addr  = {32{grant_req}} & (grant_src ? data.addr  : inst.addr);
  assign sram.wstrb = {4{grant_req}}  & (grant_src ? data.wstrb : inst.wstrb);
  assign sram.wdata = {32{grant_req}} & (grant_src ? data.wdata : inst.wdata);

  assign inst.addr_ok = accept && !grant_src;
  assign data.addr_ok = accept && grant_src;
  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop && head;
  assign inst.rdata   = inst.data_ok ? sram.rdata : '0;
  assign data.rdata   = data.data_ok ? sram.rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      lock_vld <= 1'b0;
      lock_src <= 1'b0;
      streak   <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr] <= grant_src;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);

      if (grant_req && !sram.addr_ok) begin
        lock_vld <= 1'b1;
        lock_src <= grant_src;
      end else if (accept) begin
        lock_vld <= 1'b0;
      end

      // Only M1 wins taken while M0 was waiting count toward the streak.
      if (accept) begin
        if (grant_src && inst.req)
          streak <= (streak == SW'(MAX_STREAK)) ? streak : streak + SW'(1);
        else
          streak <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the arbitration rules.
module tb_sram_port_arbiter;
  localparam int OUTST      = 2;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_port_arbiter_if inst_if();
  sram_port_arbiter_if data_if();
  sram_port_arbiter_if sram_if();

  sram_port_arbiter #(.OUTST(OUTST), .MAX_STREAK(MAX_STREAK)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .sram  (sram_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: owners of outstanding transactions (0=M0, 1=M1), oldest first.
  int mq[$];
  bit m_lock_vld = 1'b0;
  bit m_lock_src = 1'b0;
  int m_streak   = 0;

  bit          exp_inst_aok, exp_data_aok;
  logic        obs_sram_req, obs_inst_aok, obs_data_aok, obs_inst_dok, obs_data_dok;
  logic [31:0] obs_sram_addr, obs_inst_rd, obs_data_rd;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic drive_inst(input bit r, input logic [31:0] a, input bit w);
    inst_if.req   = r;
    inst_if.addr  = a;
    inst_if.wr    = w;
    inst_if.size  = 2'($urandom_range(0, 2));
    inst_if.wstrb = 4'($urandom);
    inst_if.wdata = $urandom;
  endtask

  task automatic drive_data(input bit r, input logic [31:0] a, input bit w);
    data_if.req   = r;
    data_if.addr  = a;
    data_if.wr    = w;
    data_if.size  = 2'($urandom_range(0, 2));
    data_if.wstrb = 4'($urandom);
    data_if.wdata = $urandom;
  endtask

  task automatic bus(input bit aok, input bit dok, input logic [31:0] rd);
    sram_if.addr_ok = aok;
    sram_if.data_ok = dok;
    sram_if.rdata   = rd;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model, returns at next negedge.
  task automatic cycle();
    bit full, e_src, e_req, pop, head, acc;
    #1;
    full = (mq.size() >= OUTST);
    if (m_lock_vld)
      e_src = m_lock_src;
    else if (m_streak >= MAX_STREAK && inst_if.req)
      e_src = 1'b0;
    else
      e_src = data_if.req;
    e_req = !full && (e_src ? data_if.req : inst_if.req);
    pop   = sram_if.data_ok && (mq.size() > 0);
    head  = 1'b0;
    if (pop) head = (mq[0] == 1);
    exp_inst_aok = e_req && !e_src && sram_if.addr_ok;
    exp_data_aok = e_req && e_src && sram_if.addr_ok;

    obs_sram_req  = sram_if.req;
    obs_sram_addr = sram_if.addr;
    obs_inst_aok  = inst_if.addr_ok;
    obs_data_aok  = data_if.addr_ok;
    obs_inst_dok  = inst_if.data_ok;
    obs_data_dok  = data_if.data_ok;
    obs_inst_rd   = inst_if.rdata;
    obs_data_rd   = data_if.rdata;

    if (chk_en) begin
      chk("sram_req", sram_if.req, e_req);
      if (e_req) begin
        chk("sram_addr",  sram_if.addr,  e_src ? data_if.addr  : inst_if.addr);
        chk("sram_wr",    sram_if.wr,    e_src ? data_if.wr    : inst_if.wr);
        chk("sram_size",  sram_if.size,  e_src ? data_if.size  : inst_if.size);
        chk("sram_wstrb", sram_if.wstrb, e_src ? data_if.wstrb : inst_if.wstrb);
        chk("sram_wdata", sram_if.wdata, e_src ? data_if.wdata : inst_if.wdata);
      end else if (!inst_if.req && !data_if.req) begin
        chk("idle_sram_addr",  sram_if.addr,  0);
        chk("idle_sram_wdata", sram_if.wdata, 0);
        chk("idle_sram_misc",  {sram_if.wr, sram_if.size, sram_if.wstrb}, 0);
      end
      chk("inst_addr_ok", inst_if.addr_ok, exp_inst_aok);
      chk("data_addr_ok", data_if.addr_ok, exp_data_aok);
      chk("inst_data_ok", inst_if.data_ok, pop && !head);
      chk("data_data_ok", data_if.data_ok, pop && head);
      chk("inst_rdata",   inst_if.rdata, (pop && !head) ? sram_if.rdata : 32'h0);
      chk("data_rdata",   data_if.rdata, (pop && head) ? sram_if.rdata : 32'h0);
    end

    acc = e_req && sram_if.addr_ok;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_lock_vld = 1'b0;
      m_lock_src = 1'b0;
      m_streak   = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(int'(e_src));
        m_lock_vld = 1'b0;
        if (e_src && inst_if.req)
          m_streak = (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
        else
          m_streak = 0;
      end else if (e_req) begin
        m_lock_vld = 1'b1;
        m_lock_src = e_src;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit p_i, p_d;
    reset = 1'b1;
    drive_inst(0, 0, 0);
    drive_data(0, 0, 0);
    bus(0, 0, 0);
    @(negedge clk);
    cycle();
    cycle();
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: idle outputs are all zero, then a solo M0 read.
    drive_inst(0, 32'hdead_beef, 1);
    drive_data(0, 32'h1234_5678, 1);
    bus(0, 0, 32'hffff_ffff);
    cycle();
    chk("t1_idle_req",    obs_sram_req, 0);
    chk("t1_idle_addr",   obs_sram_addr, 0);
    chk("t1_idle_oks",    {obs_inst_aok, obs_data_aok, obs_inst_dok, obs_data_dok}, 0);
    chk("t1_idle_irdata", obs_inst_rd, 0);
    chk("t1_idle_drdata", obs_data_rd, 0);
    drive_inst(1, 32'h1c00_0000, 0);
    bus(1, 0, 0);
    cycle();
    chk("t1_inst_aok", obs_inst_aok, 1);
    chk("t1_data_aok", obs_data_aok, 0);
    chk("t1_addr",     obs_sram_addr, 32'h1c00_0000);
    drive_inst(0, 0, 0);
    bus(0, 0, 0);
    cycle();
    chk("t1_wait_aok", obs_inst_aok, 0);
    bus(0, 1, 32'h0280_0000);
    cycle();
    chk("t1_inst_dok",   obs_inst_dok, 1);
    chk("t1_inst_rdata", obs_inst_rd, 32'h0280_0000);
    chk("t1_data_dok",   obs_data_dok, 0);
    chk("t1_data_rdata", obs_data_rd, 0);

    // 2: simultaneous requests, M1 first, in-order return.
    drive_inst(1, 32'h0000_0100, 0);
    drive_data(1, 32'h0000_0200, 0);
    bus(1, 0, 0);
    cycle();
    chk("t2_data_aok", obs_data_aok, 1);
    chk("t2_inst_aok0", obs_inst_aok, 0);
    drive_data(0, 0, 0);
    cycle();
    chk("t2_inst_aok", obs_inst_aok, 1);
    drive_inst(0, 0, 0);
    bus(0, 1, 32'h0000_000a);
    cycle();
    chk("t2_data_dok", obs_data_dok, 1);
    chk("t2_data_rd",  obs_data_rd, 32'h0000_000a);
    bus(0, 1, 32'h0000_000b);
    cycle();
    chk("t2_inst_dok", obs_inst_dok, 1);
    chk("t2_inst_rd",  obs_inst_rd, 32'h0000_000b);

    // 3: a stalled M1 address phase keeps the port.
    drive_data(1, 32'h0000_0300, 1);
    bus(0, 0, 0);
    cycle();
    chk("t3_addr_c1", obs_sram_addr, 32'h0000_0300);
    drive_inst(1, 32'h0000_0400, 0);
    cycle();
    chk("t3_addr_c2", obs_sram_addr, 32'h0000_0300);
    chk("t3_inst_aok_c2", obs_inst_aok, 0);
    cycle();
    chk("t3_addr_c3", obs_sram_addr, 32'h0000_0300);
    bus(1, 0, 0);
    cycle();
    chk("t3_data_aok", obs_data_aok, 1);
    chk("t3_inst_aok_c4", obs_inst_aok, 0);
    drive_data(0, 0, 0);
    cycle();
    chk("t3_inst_aok", obs_inst_aok, 1);
    drive_inst(0, 0, 0);
    bus(0, 1, 32'h0000_0033);
    cycle();
    cycle();

    // 4: continuous contention gives four M1 grants then one M0.
    drive_inst(1, $urandom, 0);
    drive_data(1, $urandom, 1);
    for (int i = 0; i < 10; i++) begin
      bus(1, 1, $urandom);
      cycle();
      chk("t4_data_aok", obs_data_aok, (i % 5) != 4);
      chk("t4_inst_aok", obs_inst_aok, (i % 5) == 4);
      if (exp_inst_aok) drive_inst(1, $urandom, 0);
      if (exp_data_aok) drive_data(1, $urandom, 1);
    end
    drive_inst(0, 0, 0);
    drive_data(0, 0, 0);
    bus(0, 1, 32'h0000_0044);
    cycle();
    chk("t4_drain_inst_dok", obs_inst_dok, 1);

    // 5: full FIFO blocks grants, no bypass on a same-cycle pop, spurious data_ok ignored.
    drive_inst(1, 32'h0000_0500, 0);
    bus(1, 0, 0);
    cycle();
    drive_inst(0, 0, 0);
    drive_data(1, 32'h0000_0600, 0);
    cycle();
    drive_data(0, 0, 0);
    drive_inst(1, 32'h0000_0700, 0);
    cycle();
    chk("t5_full_req", obs_sram_req, 0);
    chk("t5_full_aok", obs_inst_aok, 0);
    bus(1, 1, 32'h0000_0011);
    cycle();
    chk("t5_nobypass_req", obs_sram_req, 0);
    chk("t5_pop_inst_dok", obs_inst_dok, 1);
    chk("t5_pop_inst_rd",  obs_inst_rd, 32'h0000_0011);
    bus(1, 0, 0);
    cycle();
    chk("t5_third_aok", obs_inst_aok, 1);
    drive_inst(0, 0, 0);
    bus(0, 1, 32'h0000_0022);
    cycle();
    chk("t5_data_dok", obs_data_dok, 1);
    chk("t5_data_rd",  obs_data_rd, 32'h0000_0022);
    bus(0, 1, 32'h0000_0033);
    cycle();
    chk("t5_inst_dok", obs_inst_dok, 1);
    bus(0, 1, 32'h0000_0044);
    cycle();
    chk("t5_spur_oks", {obs_inst_dok, obs_data_dok}, 0);
    chk("t5_spur_rd",  obs_inst_rd | obs_data_rd, 0);

    // 6: reset with two outstanding empties the FIFO.
    drive_inst(1, 32'h0000_0800, 0);
    bus(1, 0, 0);
    cycle();
    drive_inst(0, 0, 0);
    drive_data(1, 32'h0000_0900, 0);
    cycle();
    drive_data(0, 0, 0);
    bus(0, 0, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive_inst(1, 32'h0000_0a00, 0);
    bus(1, 0, 0);
    cycle();
    chk("t6_req1", obs_sram_req, 1);
    chk("t6_aok1", obs_inst_aok, 1);
    drive_inst(0, 0, 0);
    drive_data(1, 32'h0000_0b00, 0);
    cycle();
    chk("t6_req2", obs_sram_req, 1);
    chk("t6_aok2", obs_data_aok, 1);
    drive_data(0, 0, 0);
    bus(0, 1, 32'h0000_0055);
    cycle();
    chk("t6_inst_dok", obs_inst_dok, 1);
    bus(0, 1, 32'h0000_0066);
    cycle();
    chk("t6_data_dok", obs_data_dok, 1);

    // Random traffic against the model.
    p_i = 1'b0;
    p_d = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      int rate;
      rate = ((k / 400) % 2 == 1) ? 2 : 5;
      if (!p_i && ($urandom % rate == 0)) begin
        drive_inst(1, $urandom, 1'($urandom));
        p_i = 1'b1;
      end else if (!p_i) begin
        drive_inst(0, $urandom, 1'($urandom));
      end
      if (!p_d && ($urandom % rate == 0)) begin
        drive_data(1, $urandom, 1'($urandom));
        p_d = 1'b1;
      end else if (!p_d) begin
        drive_data(0, $urandom, 1'($urandom));
      end
      reset = ($urandom % 700 == 0);
      bus($urandom % 4 != 0,
          (mq.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 16 == 0),
          $urandom);
      cycle();
      if (exp_inst_aok) p_i = 1'b0;
      if (exp_data_aok) p_d = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
